// File: rtl/debounce_seven_seg_pkg.sv
// Shared constants for the debouncer / seven-segment front end: segment codes,
// scan-state encoding and digit count.
package debounce_seven_seg_pkg;

   localparam int NUM_DIGITS = 8;

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [2:0] {
      DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7
   } scan_state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/debounce_seven_seg_button_debounce.sv
// Button debouncer: 2-flop synchronizer, stability counter, registered level
// and one-cycle rising-edge pulse.
module button_debounce
   import debounce_seven_seg_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_db,
   output logic btn_rise
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q;
   logic          btn_sync;
   logic [CW-1:0] stab_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q   <= 1'b0;
         btn_sync <= 1'b0;
         stab_cnt <= '0;
         btn_db   <= 1'b0;
         btn_rise <= 1'b0;
      end else begin
         sync_q   <= btn_raw;
         btn_sync <= sync_q;
         btn_rise <= 1'b0;
         if (btn_sync != btn_db) begin
            // Level flips only after DEBOUNCE_CYCLES consecutive differing samples
            if (stab_cnt == CNT_LAST) begin
               btn_db   <= ~btn_db;
               btn_rise <= ~btn_db;
               stab_cnt <= '0;
            end else begin
               stab_cnt <= stab_cnt + 1'b1;
            end
         end else begin
            stab_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/debounce_seven_seg.sv
// Debounced button plus 8-digit multiplexed common-anode display (dec/hex).
// Build option LEADING_ZERO_BLANK_EN blanks leading zeros in decimal mode.
//
// state | meaning
// DIG0  | digit 0 (rightmost) lit; shadow value/mode captured on entry
// DIG1  | digit 1 lit
// DIG2  | digit 2 lit in decimal mode, dark in hex
// DIG3-7| all digits dark (anode all ones)
module debounce_seven_seg
   import debounce_seven_seg_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REFRESH_CYCLES  = 100_000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  btn_raw,
   input  logic                  mode,
   input  logic [7:0]            value,
   output logic                  btn_db,
   output logic                  btn_rise,
   output logic [6:0]            cathode,
   output logic [NUM_DIGITS-1:0] anode
);

   localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_button_debounce (
      .clock    (clock),
      .reset    (reset),
      .btn_raw  (btn_raw),
      .btn_db   (btn_db),
      .btn_rise (btn_rise)
   );

   logic [RW-1:0]         ref_cnt;
   logic                  ref_wrap;
   scan_state_t           state;
   scan_state_t           state_nxt;
   logic [7:0]            shadow_value;
   logic                  shadow_mode;
   logic [7:0]            tens_all;
   logic [3:0]            dig_ones;
   logic [3:0]            dig_tens;
   logic [3:0]            dig_hund;
   logic [3:0]            nib;
   logic                  lit;
   logic                  blank;
   logic [NUM_DIGITS-1:0] anode_nxt;
   logic [6:0]            cathode_nxt;

   assign ref_wrap = (ref_cnt == REF_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         ref_cnt <= '0;
      end else if (ref_wrap) begin
         ref_cnt <= '0;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= DIG0;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (ref_wrap) begin
         state_nxt = scan_state_t'(state + 3'd1);
      end
   end

   // Snapshot on the DIG7->DIG0 step so a whole scan shows one consistent value
   always_ff @(posedge clock) begin
      if (reset) begin
         shadow_value <= 8'd0;
         shadow_mode  <= 1'b1;
      end else if (ref_wrap && (state == DIG7)) begin
         shadow_value <= value;
         shadow_mode  <= mode;
      end
   end

   always_comb begin
      tens_all = shadow_value / 8'd10;
      dig_ones = 4'(shadow_value % 8'd10);
      dig_tens = 4'(tens_all % 8'd10);
      dig_hund = 4'(shadow_value / 8'd100);
   end

   always_comb begin
      anode_nxt   = '1;
      cathode_nxt = SEG_BLANK;
      nib         = 4'd0;
      lit         = 1'b0;
      blank       = 1'b0;
      if (shadow_mode) begin
         case (state)
            DIG0: begin
               lit = 1'b1;
               nib = dig_ones;
            end
            DIG1: begin
               lit = 1'b1;
               nib = dig_tens;
`ifdef LEADING_ZERO_BLANK_EN
               blank = (dig_hund == 4'd0) && (dig_tens == 4'd0);
`else
               blank = 1'b0;
`endif
            end
            DIG2: begin
               lit = 1'b1;
               nib = dig_hund;
`ifdef LEADING_ZERO_BLANK_EN
               blank = (dig_hund == 4'd0);
`else
               blank = 1'b0;
`endif
            end
            default: lit = 1'b0;
         endcase
      end else begin
         case (state)
            DIG0: begin
               lit = 1'b1;
               nib = shadow_value[3:0];
            end
            DIG1: begin
               lit = 1'b1;
               nib = shadow_value[7:4];
            end
            default: lit = 1'b0;
         endcase
      end
      if (lit) begin
         anode_nxt   = ~(NUM_DIGITS'(1) << state);
         cathode_nxt = blank ? SEG_BLANK : seg_decode(nib);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         anode   <= '1;
         cathode <= SEG_BLANK;
      end else begin
         anode   <= anode_nxt;
         cathode <= cathode_nxt;
      end
   end

endmodule

// File: tb/tb_debounce_seven_seg.sv
// Scoreboard bench for debounce_seven_seg with DEBOUNCE_CYCLES=4, REFRESH_CYCLES=2.
module tb_debounce_seven_seg;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_raw = 1'b0;
   logic       mode = 1'b1;
   logic [7:0] value = 8'd0;
   logic       btn_db;
   logic       btn_rise;
   logic [6:0] cathode;
   logic [7:0] anode;

   debounce_seven_seg #(
      .DEBOUNCE_CYCLES (4),
      .REFRESH_CYCLES  (2)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .btn_raw  (btn_raw),
      .mode     (mode),
      .value    (value),
      .btn_db   (btn_db),
      .btn_rise (btn_rise),
      .cathode  (cathode),
      .anode    (anode)
   );

   always #5 clock = ~clock;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'b1111111;
`else
   localparam logic [6:0] LZ = 7'b1000000;
`endif

   typedef struct {
      int         dig;
      logic [7:0] an;
      logic [6:0] cat;
   } disp_exp_t;

   typedef struct {
      int   cyc;
      logic lvl;
   } lvl_exp_t;

   disp_exp_t dq[$];
   lvl_exp_t  lq[$];
   int        rq[$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic rst_applied = 1'b0;

   // Directed display scans: value, mode, expected cathode of digits 0..2
   logic [7:0] t_val  [7] = '{8'd237, 8'hAF, 8'd7, 8'd200, 8'h3C, 8'd10, 8'd255};
   logic       t_mode [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [6:0] t_c0   [7] = '{7'b1111000, 7'b0001110, 7'b1111000, 7'b1000000,
                              7'b1000110, 7'b1000000, 7'b0010010};
   logic [6:0] t_c1   [7] = '{7'b0110000, 7'b0001000, LZ, 7'b1000000,
                              7'b0110000, 7'b1111001, 7'b0010010};
   logic [6:0] t_c2   [7] = '{7'b0100100, 7'b1111111, LZ, 7'b0100100,
                              7'b1111111, LZ, 7'b0100100};
   logic       t_mid  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clock) begin
      rst_applied <= reset;
      cyc         <= reset ? 0 : cyc + 1;
   end

   // Monitor: compares whatever the DUT presents against queued expectations
   disp_exp_t de;
   lvl_exp_t  le;
   int        dnow;
   always @(negedge clock) begin
      if (rst_applied) begin
         chk("rst_anode", anode, 8'hFF);
         chk("rst_cathode", cathode, 7'h7F);
         chk("rst_btn_db", btn_db, 1'b0);
         chk("rst_btn_rise", btn_rise, 1'b0);
      end else begin
         if (lq.size() > 0 && lq[0].cyc == cyc) begin
            le = lq.pop_front();
            chk("btn_db", btn_db, le.lvl);
         end
         if (rq.size() > 0 && rq[0] == cyc) begin
            void'(rq.pop_front());
            chk("btn_rise", btn_rise, 1'b1);
         end else if (btn_rise) begin
            chk("btn_rise_spurious", btn_rise, 1'b0);
         end
         if (cyc >= 1 && (cyc % 2) == 1) begin
            dnow = ((cyc - 1) / 2) % 8;
            if (dq.size() > 0 && dq[0].dig == dnow) begin
               de = dq.pop_front();
               chk($sformatf("anode_dig%0d", dnow), anode, de.an);
               if (de.an != 8'hFF)
                  chk($sformatf("cathode_dig%0d", dnow), cathode, de.cat);
            end
         end
      end
   end

   task automatic push_lv(input int c, input logic l);
      lvl_exp_t e;
      e.cyc = c;
      e.lvl = l;
      lq.push_back(e);
   endtask

   task automatic push_scan(input logic [6:0] c0, input logic [6:0] c1,
                            input logic [6:0] c2, input logic dec);
      for (int d = 0; d < 8; d++) begin
         disp_exp_t e;
         e.dig = d;
         e.an  = 8'hFF;
         e.cat = 7'h7F;
         if (d == 0) begin
            e.an  = 8'hFE;
            e.cat = c0;
         end else if (d == 1) begin
            e.an  = 8'hFD;
            e.cat = c1;
         end else if (d == 2 && dec) begin
            e.an  = 8'hFB;
            e.cat = c2;
         end
         dq.push_back(e);
      end
   endtask

   task automatic wait_digit(input int dg);
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 40 && !hit; n++) begin
         @(negedge clock);
         hit = (cyc % 2 == 1) && (((cyc - 1) / 2) % 8 == dg);
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL wait_digit: digit %0d not reached within 40 cycles", dg);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      push_scan(7'b1000000, LZ, LZ, 1'b1);
      repeat (4) @(negedge clock);

      // Clean press then release
      c = cyc;
      btn_raw = 1'b1;
      push_lv(c + 5, 1'b0);
      push_lv(c + 6, 1'b1);
      rq.push_back(c + 6);
      repeat (12) @(negedge clock);
      c = cyc;
      btn_raw = 1'b0;
      push_lv(c + 5, 1'b1);
      push_lv(c + 6, 1'b0);
      repeat (12) @(negedge clock);

      // Five 3-cycle glitches
      for (int k = 0; k < 5; k++) begin
         c = cyc;
         btn_raw = 1'b1;
         push_lv(c + 6, 1'b0);
         repeat (3) @(negedge clock);
         btn_raw = 1'b0;
         repeat (3) @(negedge clock);
      end

      // Toggle every cycle
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         btn_raw = ~btn_raw;
         if (i % 4 == 3) push_lv(cyc + 3, 1'b0);
      end
      repeat (10) @(negedge clock);

      // Reset mid-debounce, then the held press debounces from scratch
      btn_raw = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      push_lv(5, 1'b0);
      push_lv(6, 1'b1);
      rq.push_back(6);
      push_scan(7'b1000000, LZ, LZ, 1'b1);

      // Display scans; value is applied during DIG7 so it lands at next DIG0
      for (int i = 0; i < 7; i++) begin
         wait_digit(7);
         value = t_val[i];
         mode  = t_mode[i];
         push_scan(t_c0[i], t_c1[i], t_c2[i], t_mode[i]);
         if (t_mid[i]) begin
            wait_digit(3);
            value = 8'd200;
         end
      end
      wait_digit(7);
      @(negedge clock);

      chk("disp_queue_drained", dq.size(), 0);
      chk("lvl_queue_drained", lq.size(), 0);
      chk("rise_queue_drained", rq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
